pll_reset_seq: RTL and testbench
================================

# pll_reset_seq

PLL reset and lock sequencer for the board clocking block. It runs on the free-running board reference clock and pulses the PLL reset. It then waits for a stable `locked` indication and only afterwards releases the system reset. On loss of lock it re-sequences the PLL and counts the failure. It sits between the board reset/reference clock pins and the system PLL, and its `sys_rst` output drives the SoC reset synchronisers.

## Interface
Parameters:
- `RST_CYCLES`, 16: refclk cycles `pll_rst` is held high in PLL_RST (≥2).
- `LOCK_STABLE_CYCLES`, 256: consecutive synchronised-locked cycles required before release (≥2).
- `LOCK_TIMEOUT_CYCLES`, 65536: maximum WAIT_LOCK duration (≥2); used only with timeout compiled in.
- `CNT_W`, 17: state counter width; must hold max(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES).

Ports:
- `refclk`, in, 1: sole clock, 50 MHz board reference; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `locked`, in, 1: PLL lock, asynchronous to refclk; 2-flop synchronised internally to `locked_s`.
- `relock_req`, in, 1: single-cycle request to re-sequence the PLL.
- `pll_rst`, out, 1: reset to PLL `rst`.
- `sys_rst`, out, 1: active-high system reset request.
- `ready`, out, 1: PLL locked and system released.
- `state`, out, 2: current state encoding.
- `fail_cnt`, out, 8: saturating count of lock losses and timeouts.

## Operation
- States: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3.
- `cnt` (CNT_W bits) clears on every state entry and increments each cycle in the state. A state lasting N cycles exits when `cnt == N-1`.
- PLL_RST: after RST_CYCLES cycles → WAIT_LOCK. `locked_s` is ignored.
- WAIT_LOCK: `locked_s`=1 → STABLE.
- STABLE: `locked_s`=0 → WAIT_LOCK, with no fail count. Otherwise, after LOCK_STABLE_CYCLES cycles → RUN.
- RUN: stays until an event:
  - `locked_s`=0 → PLL_RST, `fail_cnt`+1.
  - else `relock_req`=1 → PLL_RST, no count.
  - Lock loss has priority when both occur in the same cycle.
- `relock_req` is ignored outside RUN. It is not latched.
- `fail_cnt` saturates at 255. It clears only on `rst`.
- Outputs are registered and decoded from the next state, so they change in the same cycle as `state`:
  - `pll_rst` = (state==PLL_RST)
  - `sys_rst` = (state!=RUN)
  - `ready` = (state==RUN)

## Timing
- During `rst`: state=PLL_RST, cnt=0, sync flops=0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail_cnt`=0.
- `rst` deassertion: `pll_rst` stays high for RST_CYCLES rising edges.
- `locked` → `locked_s` latency: 2 cycles.
- Minimum rst-release to `sys_rst` low: RST_CYCLES + 1 + LOCK_STABLE_CYCLES cycles (273 at defaults).
- Lock loss in RUN: `sys_rst`=1 and `pll_rst`=1 three edges after `locked` falls (2 sync + 1 state).
- `rst` asserted mid-sequence: immediate, asynchronous return to reset values, including `fail_cnt`.
- `locked` glitch shorter than 1 cycle may be missed. A glitch of ≥2 cycles is always seen.

## Configuration
- `PLL_LOCK_TIMEOUT_EN` defined: in WAIT_LOCK, at `cnt == LOCK_TIMEOUT_CYCLES-1` with `locked_s`=0 → PLL_RST, `fail_cnt`+1 (saturating). If `locked_s`=1 in that same cycle, the transition is to STABLE instead.
- Not defined: WAIT_LOCK waits indefinitely. LOCK_TIMEOUT_CYCLES is unused.

## Test plan
- Power-up, `locked`=1 throughout (defaults) → `pll_rst` high 16 cycles after release; `sys_rst` falls and `ready` rises exactly 273 cycles after release; `fail_cnt`=0.
- Lock bounce: `locked` drops for 3 cycles at STABLE cnt=100 → returns to WAIT_LOCK; STABLE restarts with a full 256 cycles; `fail_cnt`=0.
- Lock loss in RUN → `sys_rst`=1 and `pll_rst`=1 on the 3rd edge; `fail_cnt`=1; re-release after a further 16+1+256 cycles once `locked` returns.
- `relock_req` in RUN with `locked`=1 → PLL_RST next cycle, `fail_cnt` unchanged. `relock_req` in STABLE → no effect.
- `PLL_LOCK_TIMEOUT_EN`, LOCK_TIMEOUT_CYCLES=32, `locked`=0 → PLL_RST every 16+32 cycles; `fail_cnt` increments each time and saturates at 255 after 255 timeouts.
- `rst` asserted in RUN with `fail_cnt`=5 → all outputs return to reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/pll_reset_seq.sv
// PLL reset and lock sequencer: pulses pll_rst, qualifies lock, releases sys_rst.
// Optional WAIT_LOCK timeout compiled in with `define PLL_LOCK_TIMEOUT_EN.
module pll_reset_seq #(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] fail_cnt
);

  localparam logic [1:0] PLL_RST   = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] STABLE    = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam logic [CNT_W-1:0] RST_LAST =
    CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
`endif

  // Reject degenerate configurations at elaboration.
  if (RST_CYCLES < 2 || LOCK_STABLE_CYCLES < 2 ||
      LOCK_TIMEOUT_CYCLES < 2) begin : g_param_err
    $error("pll_reset_seq: cycle parameters must be >= 2");
  end

  logic             locked_m;
  logic             locked_s;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state_n;
  logic             fail_inc;

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= locked;
      locked_s <= locked_m;
    end
  end

  // Next-state decode; lock loss outranks a relock request.
  always_comb begin
    state_n  = state;
    fail_inc = 1'b0;
    unique case (state)
      PLL_RST: begin
        if (cnt == RST_LAST)
          state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s)
          state_n = STABLE;
`ifdef PLL_LOCK_TIMEOUT_EN
        else if (cnt == TO_LAST) begin
          state_n  = PLL_RST;
          fail_inc = 1'b1;
        end
`endif
      end
      STABLE: begin
        if (!locked_s)
          state_n = WAIT_LOCK;
        else if (cnt == STABLE_LAST)
          state_n = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_n  = PLL_RST;
          fail_inc = 1'b1;
        end else if (relock_req) begin
          state_n = PLL_RST;
        end
      end
      default: state_n = PLL_RST;
    endcase
  end

  // State register and per-state cycle counter, cleared on entry.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= PLL_RST;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  // Outputs registered from the next state to align with state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
    end else begin
      pll_rst <= (state_n == PLL_RST);
      sys_rst <= (state_n != RUN);
      ready   <= (state_n == RUN);
    end
  end

  // Saturating failure counter, cleared only by rst.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst)
      fail_cnt <= 8'd0;
    else if (fail_inc && fail_cnt != 8'hFF)
      fail_cnt <= fail_cnt + 8'd1;
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed testbench for pll_reset_seq at default cycle counts.
// Timeout scenario runs only when PLL_LOCK_TIMEOUT_EN is defined.
module tb_pll_reset_seq;

  logic       refclk;
  logic       rst;
  logic       locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [1:0] state;
  logic [7:0] fail_cnt;

  int checks;
  int errors;

  pll_reset_seq #(
    .RST_CYCLES(16),
    .LOCK_STABLE_CYCLES(256),
    .LOCK_TIMEOUT_CYCLES(32),
    .CNT_W(17)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .locked(locked),
    .relock_req(relock_req),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .state(state),
    .fail_cnt(fail_cnt)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    locked = 1'b1;
    relock_req = 1'b0;
    tick(3);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL rst_pll_rst got %b want 1", pll_rst);
    end
    checks++;
    if (sys_rst !== 1'b1) begin
      errors++;
      $display("FAIL rst_sys_rst got %b want 1", sys_rst);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready got %b want 0", ready);
    end
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL rst_state got %0d want 0", state);
    end
    checks++;
    if (fail_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_fail got %0d want 0", fail_cnt);
    end
  endtask

  task automatic test_powerup;
    rst = 1'b0;
    tick(15);
    checks++;
    if (pll_rst !== 1'b1) begin
      errors++;
      $display("FAIL pwr_pll_e15 got %b want 1", pll_rst);
    end
    tick(1);
    checks++;
    if (pll_rst !== 1'b0 || state !== 2'd1) begin
      errors++;
      $display("FAIL pwr_e16 got pll=%b st=%0d want 0/1",
               pll_rst, state);
    end
    tick(1);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL pwr_e17 got st=%0d want 2", state);
    end
    tick(255);
    checks++;
    if (sys_rst !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL pwr_e272 got sys=%b rdy=%b want 1/0",
               sys_rst, ready);
    end
    tick(1);
    checks++;
    if (sys_rst !== 1'b0 || ready !== 1'b1 ||
        state !== 2'd3 || fail_cnt !== 8'd0) begin
      errors++;
      $display("FAIL pwr_e273 got sys=%b rdy=%b st=%0d f=%0d want 0/1/3/0",
               sys_rst, ready, state, fail_cnt);
    end
  endtask

  task automatic test_relock_bounce;
    tick(5);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++;
    if (state !== 2'd0 || pll_rst !== 1'b1 ||
        fail_cnt !== 8'd0) begin
      errors++;
      $display("FAIL relock_run got st=%0d pll=%b f=%0d want 0/1/0",
               state, pll_rst, fail_cnt);
    end
    tick(16);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL relock_wait got st=%0d want 1", state);
    end
    tick(1);
    tick(30);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++;
    if (state !== 2'd2 || pll_rst !== 1'b0) begin
      errors++;
      $display("FAIL relock_stable got st=%0d pll=%b want 2/0",
               state, pll_rst);
    end
    tick(69);
    locked = 1'b0;
    tick(2);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL bounce_hold got st=%0d want 2", state);
    end
    tick(1);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL bounce_wait got st=%0d want 1", state);
    end
    locked = 1'b1;
    tick(2);
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL bounce_still got st=%0d want 1", state);
    end
    tick(1);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL bounce_restab got st=%0d want 2", state);
    end
    tick(255);
    checks++;
    if (state !== 2'd2 || sys_rst !== 1'b1) begin
      errors++;
      $display("FAIL bounce_full got st=%0d sys=%b want 2/1",
               state, sys_rst);
    end
    tick(1);
    checks++;
    if (state !== 2'd3 || fail_cnt !== 8'd0) begin
      errors++;
      $display("FAIL bounce_run got st=%0d f=%0d want 3/0",
               state, fail_cnt);
    end
  endtask

  task automatic test_lock_loss;
    locked = 1'b0;
    tick(2);
    checks++;
    if (state !== 2'd3 || sys_rst !== 1'b0) begin
      errors++;
      $display("FAIL loss_e2 got st=%0d sys=%b want 3/0",
               state, sys_rst);
    end
    tick(1);
    checks++;
    if (state !== 2'd0 || sys_rst !== 1'b1 ||
        pll_rst !== 1'b1 || fail_cnt !== 8'd1) begin
      errors++;
      $display("FAIL loss_e3 got st=%0d sys=%b pll=%b f=%0d want 0/1/1/1",
               state, sys_rst, pll_rst, fail_cnt);
    end
    locked = 1'b1;
    tick(272);
    checks++;
    if (sys_rst !== 1'b1) begin
      errors++;
      $display("FAIL loss_pre got sys=%b want 1", sys_rst);
    end
    tick(1);
    checks++;
    if (ready !== 1'b1 || fail_cnt !== 8'd1) begin
      errors++;
      $display("FAIL loss_rerun got rdy=%b f=%0d want 1/1",
               ready, fail_cnt);
    end
  endtask

  task automatic test_priority;
    locked = 1'b0;
    tick(2);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    checks++;
    if (state !== 2'd0 || fail_cnt !== 8'd2) begin
      errors++;
      $display("FAIL prio got st=%0d f=%0d want 0/2",
               state, fail_cnt);
    end
    locked = 1'b1;
    tick(273);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_rerun got rdy=%b want 1", ready);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      tick(273);
    end
    checks++;
    if (ready !== 1'b1 || fail_cnt !== 8'd5) begin
      errors++;
      $display("FAIL b2b got rdy=%b f=%0d want 1/5",
               ready, fail_cnt);
    end
  endtask

  task automatic test_async_rst;
    #5;
    rst = 1'b1;
    #1;
    checks++;
    if (pll_rst !== 1'b1 || sys_rst !== 1'b1 ||
        ready !== 1'b0 || state !== 2'd0 ||
        fail_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_rst got pll=%b sys=%b rdy=%b st=%0d f=%0d",
               pll_rst, sys_rst, ready, state, fail_cnt);
    end
    tick(2);
  endtask

`ifdef PLL_LOCK_TIMEOUT_EN
  task automatic test_timeout;
    rst = 1'b1;
    locked = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(47);
    checks++;
    if (state !== 2'd1 || fail_cnt !== 8'd0) begin
      errors++;
      $display("FAIL to_e47 got st=%0d f=%0d want 1/0",
               state, fail_cnt);
    end
    tick(1);
    checks++;
    if (state !== 2'd0 || fail_cnt !== 8'd1) begin
      errors++;
      $display("FAIL to_e48 got st=%0d f=%0d want 0/1",
               state, fail_cnt);
    end
    tick(254 * 48);
    checks++;
    if (fail_cnt !== 8'd255 || state !== 2'd0) begin
      errors++;
      $display("FAIL to_255 got st=%0d f=%0d want 0/255",
               state, fail_cnt);
    end
    tick(48);
    checks++;
    if (fail_cnt !== 8'd255 || state !== 2'd0) begin
      errors++;
      $display("FAIL to_sat got st=%0d f=%0d want 0/255",
               state, fail_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    locked = 1'b1;
    relock_req = 1'b0;
    test_reset();
    test_powerup();
    test_relock_bounce();
    test_lock_loss();
    test_priority();
    test_back_to_back();
    test_async_rst();
`ifdef PLL_LOCK_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
